// File: rtl/nfault_line_driver_pkg.sv
// Shared types and defaults for the nFault line driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nfault_line_driver_pkg;

  typedef enum logic [1:0] {
    D_RELEASED   = 2'd0,
    D_DRIVE_MIN  = 2'd1,
    D_DRIVE      = 2'd2,
    D_TURNAROUND = 2'd3
  } driver_state_t;

  localparam int DEF_NUM_SOURCES       = 4;
  localparam int DEF_MIN_DRIVE_CYCLES  = 4;
  localparam int DEF_TURNAROUND_CYCLES = 2;
  localparam int DEF_COUNT_WIDTH       = 8;

  // Width of a down-counter that must hold values 0..max(a,b)-1 (never below 1 bit).
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/nfault_line_driver_if.sv
// Bundles strobes, fault inputs and registered status/pad outputs of the line driver.
// Latency: n/a (wiring only).
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
interface nfault_line_driver_if
  import nfault_line_driver_pkg::*;
#(
  parameter int NUM_SOURCES = DEF_NUM_SOURCES,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
);

  logic                   set_nFault_value;
  logic                   set_nFault_z;
  logic [NUM_SOURCES-1:0] fault_event;
  logic [NUM_SOURCES-1:0] fault_mask;
  logic                   clear_faults;
  logic                   nFault_oe;
  logic                   nFault_o;
  logic [NUM_SOURCES-1:0] fault_status;
  logic                   fault_active;
  logic [COUNT_WIDTH-1:0] fault_count;
  logic                   driver_busy;

  modport master (
    output set_nFault_value, set_nFault_z, fault_event, fault_mask, clear_faults,
    input  nFault_oe, nFault_o, fault_status, fault_active, fault_count, driver_busy
  );

  modport slave (
    input  set_nFault_value, set_nFault_z, fault_event, fault_mask, clear_faults,
    output nFault_oe, nFault_o, fault_status, fault_active, fault_count, driver_busy
  );

endinterface

// File: rtl/nfault_line_driver_fault_latch.sv
// Sticky per-source fault register with mask, clear and saturating new-event counter.
// Latency: 1 cycle from fault_event to fault_status/fault_active/fault_count.
// Backpressure: none; events are sampled every cycle and never dropped, even on clear.
module nfault_line_driver_fault_latch
  import nfault_line_driver_pkg::*;
#(
  parameter int NUM_SOURCES = DEF_NUM_SOURCES,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] fault_event,
  input  logic [NUM_SOURCES-1:0] fault_mask,
  input  logic                   clear_faults,
  output logic                   active_nxt,
  output logic [NUM_SOURCES-1:0] fault_status,
  output logic                   fault_active,
  output logic [COUNT_WIDTH-1:0] fault_count
);

  logic [NUM_SOURCES-1:0] new_evt;
  logic [NUM_SOURCES-1:0] status_nxt;
  logic [COUNT_WIDTH-1:0] count_nxt;

  // Next status/count: clear replaces history with this cycle's events so nothing is lost.
  always_comb begin
    new_evt    = fault_event & ~fault_mask;
    status_nxt = fault_status | new_evt;
    count_nxt  = fault_count;
    if (clear_faults) begin
      status_nxt = new_evt;
      count_nxt  = (|new_evt) ? COUNT_WIDTH'(1) : '0;
    end else if ((|(new_evt & ~fault_status)) && (fault_count != '1)) begin
      count_nxt = fault_count + COUNT_WIDTH'(1);
    end
    active_nxt = |status_nxt;
  end

  // Status, summary and counter registers; fault_active tracks status in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_status <= '0;
      fault_active <= 1'b0;
      fault_count  <= '0;
    end else begin
      fault_status <= status_nxt;
      fault_active <= active_nxt;
      fault_count  <= count_nxt;
    end
  end

endmodule

// File: rtl/nfault_line_driver.sv
// Drives the shared open-drain nFault line with minimum drive time and turnaround gap.
// Latency: nFault_oe follows a strobe by 1 cycle; nFault_o follows fault_event by 1 cycle.
// Backpressure: none; strobes landing in a hold window are recorded or ignored, never stalled.
module nfault_line_driver
  import nfault_line_driver_pkg::*;
#(
  parameter int NUM_SOURCES       = DEF_NUM_SOURCES,
  parameter int MIN_DRIVE_CYCLES  = DEF_MIN_DRIVE_CYCLES,
  parameter int TURNAROUND_CYCLES = DEF_TURNAROUND_CYCLES,
  parameter int COUNT_WIDTH       = DEF_COUNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  nfault_line_driver_if.slave   bus
);

  localparam int TW = timer_width(MIN_DRIVE_CYCLES, TURNAROUND_CYCLES);
  localparam logic [TW-1:0] MIN_LOAD  = TW'(MIN_DRIVE_CYCLES - 1);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURNAROUND_CYCLES - 1);

  driver_state_t state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          release_pending, release_pending_nxt;
  logic          value_pending, value_pending_nxt;
  logic          value_req;
  logic          drive_nxt;
  logic          active_nxt;

  nfault_line_driver_fault_latch #(
    .NUM_SOURCES (NUM_SOURCES),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_fault_latch (
    .clk          (clk),
    .reset        (reset),
    .fault_event  (bus.fault_event),
    .fault_mask   (bus.fault_mask),
    .clear_faults (bus.clear_faults),
    .active_nxt   (active_nxt),
    .fault_status (bus.fault_status),
    .fault_active (bus.fault_active),
    .fault_count  (bus.fault_count)
  );

  // Release strobe beats a coincident drive strobe everywhere.
  assign value_req = bus.set_nFault_value & ~bus.set_nFault_z;

  // Next-state logic: timer counts down the hold window of the current state.
  always_comb begin
    state_nxt           = state;
    timer_nxt           = timer;
    release_pending_nxt = release_pending;
    value_pending_nxt   = value_pending;
    case (state)
      D_RELEASED: begin
        if (value_req) begin
          state_nxt           = D_DRIVE_MIN;
          timer_nxt           = MIN_LOAD;
          release_pending_nxt = 1'b0;
        end
      end
      D_DRIVE_MIN: begin
        if (bus.set_nFault_z) release_pending_nxt = 1'b1;
        if (timer == '0) begin
          if (release_pending_nxt) begin
            state_nxt           = D_TURNAROUND;
            timer_nxt           = TURN_LOAD;
            release_pending_nxt = 1'b0;
            value_pending_nxt   = 1'b0;
          end else begin
            state_nxt = D_DRIVE;
          end
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      D_DRIVE: begin
        if (bus.set_nFault_z) begin
          state_nxt         = D_TURNAROUND;
          timer_nxt         = TURN_LOAD;
          value_pending_nxt = 1'b0;
        end
      end
      D_TURNAROUND: begin
        if (bus.set_nFault_z)          value_pending_nxt = 1'b0;
        else if (bus.set_nFault_value) value_pending_nxt = 1'b1;
        if (timer == '0) begin
          if (value_pending_nxt) begin
            state_nxt           = D_DRIVE_MIN;
            timer_nxt           = MIN_LOAD;
            release_pending_nxt = 1'b0;
            value_pending_nxt   = 1'b0;
          end else begin
            state_nxt = D_RELEASED;
          end
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      default: begin
        state_nxt           = D_RELEASED;
        timer_nxt           = '0;
        release_pending_nxt = 1'b0;
        value_pending_nxt   = 1'b0;
      end
    endcase
    drive_nxt = (state_nxt == D_DRIVE_MIN) || (state_nxt == D_DRIVE);
  end

  // State and registered pad outputs; reset drops the line without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= D_RELEASED;
      timer           <= '0;
      release_pending <= 1'b0;
      value_pending   <= 1'b0;
      bus.nFault_oe   <= 1'b0;
      bus.nFault_o    <= 1'b1;
      bus.driver_busy <= 1'b0;
    end else begin
      state           <= state_nxt;
      timer           <= timer_nxt;
      release_pending <= release_pending_nxt;
      value_pending   <= value_pending_nxt;
      bus.nFault_oe   <= drive_nxt;
      bus.nFault_o    <= drive_nxt ? ~active_nxt : 1'b1;
      bus.driver_busy <= (state_nxt != D_RELEASED);
    end
  end

endmodule
